// File: rtl/bms_share_sequencer_if.sv
// rtl/bms_share_sequencer_if.sv - request/ack bus to the shared FP unit
interface bms_share_sequencer_if;
    logic        op_req;
    logic [1:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ack;
    logic [31:0] op_result;

    modport master (output op_req, op_code, op_a, op_b, input op_ack, op_result);
    modport slave  (input op_req, op_code, op_a, op_b, output op_ack, op_result);
endinterface

// File: rtl/bms_share_sequencer.sv
// rtl/bms_share_sequencer.sv - SOC-weighted pack current split over a shared FP unit
module bms_share_sequencer #(
    parameter int OP_TIMEOUT = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [31:0]                  soc1,
    input  logic [31:0]                  soc2,
    input  logic [31:0]                  soc3,
    input  logic [31:0]                  soc4,
    input  logic [31:0]                  I,
    bms_share_sequencer_if.master        fp,
    output logic [31:0]                  i1,
    output logic [31:0]                  i2,
    output logic [31:0]                  i3,
    output logic [31:0]                  i4,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    localparam int CW = $clog2(OP_TIMEOUT + 1);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_RCP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_CLASSIFY, S_RECIP, S_SUM, S_DEN_RECIP, S_SCALE, S_SHARE, S_FINISH
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_soc [4];
    logic [31:0] r_w   [4];
    logic [31:0] r_r   [4];
    logic [31:0] r_i   [4];
    logic [31:0] r_I;
    logic [31:0] r_acc;
    logic [31:0] r_rden;
    logic [31:0] r_kscale;
    logic [1:0]  r_idx;
    logic [CW-1:0] r_cnt;
    logic        r_err;

    logic        w_zero;
    logic        w_sel;
    logic        w_ack;
    logic        w_timeout;
    logic        w_last;
    logic        w_op_state;
    logic [1:0]  w_op_code;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;

    // Classification is pure bit testing on the latched pack current
    assign w_zero    = (r_I[30:0] == 31'd0);
    assign w_sel     = r_I[31];
    // Acks only count while a request is outstanding
    assign w_ack     = fp.op_req & fp.op_ack;
    assign w_timeout = fp.op_req & ~fp.op_ack & (r_cnt == CW'(OP_TIMEOUT - 1));
    assign w_last    = (r_state == S_SUM) ? (r_idx == 2'd2) :
                       ((r_state == S_RECIP) || (r_state == S_SHARE)) ? (r_idx == 2'd3) : 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; every operation stage leaves early on timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_CLASSIFY;
            S_CLASSIFY:  w_next = w_zero ? S_FINISH : (w_sel ? S_RECIP : S_SUM);
            S_RECIP:     if (w_timeout) w_next = S_FINISH; else if (w_ack && w_last) w_next = S_SUM;
            S_SUM:       if (w_timeout) w_next = S_FINISH; else if (w_ack && w_last) w_next = S_DEN_RECIP;
            S_DEN_RECIP: if (w_timeout) w_next = S_FINISH; else if (w_ack) w_next = S_SCALE;
            S_SCALE:     if (w_timeout) w_next = S_FINISH; else if (w_ack) w_next = S_SHARE;
            S_SHARE:     if (w_timeout) w_next = S_FINISH; else if (w_ack && w_last) w_next = S_FINISH;
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Operand selection for the pending operation, plus status decode
    always_comb begin
        w_op_state = 1'b1;
        w_op_code  = OP_ADD;
        w_op_a     = 32'd0;
        w_op_b     = 32'd0;
        case (r_state)
            S_RECIP:     begin w_op_code = OP_RCP; w_op_a = r_soc[r_idx]; end
            S_SUM:       begin
                             w_op_a = (r_idx == 2'd0) ? r_w[0] : r_acc;
                             w_op_b = r_w[r_idx + 2'd1];
                         end
            S_DEN_RECIP: begin w_op_code = OP_RCP; w_op_a = r_acc; end
            S_SCALE:     begin w_op_code = OP_MUL; w_op_a = r_I; w_op_b = r_rden; end
            S_SHARE:     begin w_op_code = OP_MUL; w_op_a = r_w[r_idx]; w_op_b = r_kscale; end
            default:     w_op_state = 1'b0;
        endcase
        busy = (r_state != S_IDLE);
        done = (r_state == S_FINISH);
    end

    assign err = r_err;
    assign i1  = r_i[0];
    assign i2  = r_i[1];
    assign i3  = r_i[2];
    assign i4  = r_i[3];

    // Datapath: latch inputs, run the request/ack handshake, store results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_soc[k] <= '0;
                r_w[k]   <= '0;
                r_r[k]   <= '0;
                r_i[k]   <= '0;
            end
            r_I        <= '0;
            r_acc      <= '0;
            r_rden     <= '0;
            r_kscale   <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            fp.op_req  <= 1'b0;
            fp.op_code <= '0;
            fp.op_a    <= '0;
            fp.op_b    <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_soc[0] <= soc1;
                r_soc[1] <= soc2;
                r_soc[2] <= soc3;
                r_soc[3] <= soc4;
                r_I      <= I;
                r_err    <= 1'b0;
            end
            if (r_state == S_CLASSIFY) begin
                r_idx <= '0;
                if (w_zero) begin
                    for (int k = 0; k < 4; k++) r_i[k] <= '0;
                end else if (!w_sel) begin
                    for (int k = 0; k < 4; k++) r_w[k] <= r_soc[k];
                end
            end
            if (w_op_state) begin
                if (!fp.op_req) begin
                    fp.op_req  <= 1'b1;
                    fp.op_code <= w_op_code;
                    fp.op_a    <= w_op_a;
                    fp.op_b    <= w_op_b;
                    r_cnt      <= '0;
                end else if (fp.op_ack) begin
                    fp.op_req <= 1'b0;
                    r_idx     <= w_last ? 2'd0 : r_idx + 2'd1;
                    case (r_state)
                        S_RECIP:     r_w[r_idx] <= fp.op_result;
                        S_SUM:       r_acc      <= fp.op_result;
                        S_DEN_RECIP: r_rden     <= fp.op_result;
                        S_SCALE:     r_kscale   <= fp.op_result;
                        default:     r_r[r_idx] <= fp.op_result;
                    endcase
                    // Publish the split on the final share so it is visible with done
                    if (r_state == S_SHARE && w_last) begin
                        r_i[0] <= r_r[0];
                        r_i[1] <= r_r[1];
                        r_i[2] <= r_r[2];
                        r_i[3] <= fp.op_result;
                    end
                end else if (w_timeout) begin
                    fp.op_req <= 1'b0;
                    r_err     <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bms_share_sequencer.sv
// tb/tb_bms_share_sequencer.sv - randomized self-checking bench for bms_share_sequencer
module tb_bms_share_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] soc1 = '0, soc2 = '0, soc3 = '0, soc4 = '0, I_in = '0;
    logic [31:0] i1, i2, i3, i4;
    logic        busy, done, err;
    logic        resp_ack = 1'b0;
    logic        ack_inject = 1'b0;
    logic [31:0] resp_result = '0;

    bms_share_sequencer_if ifc ();
    assign ifc.op_ack    = resp_ack | ack_inject;
    assign ifc.op_result = resp_result;

    bms_share_sequencer #(.OP_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .soc1(soc1), .soc2(soc2), .soc3(soc3), .soc4(soc4), .I(I_in),
        .fp(ifc),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int lat_min = 3, lat_max = 3;
    bit hold_off = 1'b0;
    bit spurious = 1'b0;
    int stable_err = 0;
    int gap_err = 0;
    logic [1:0]  cap_code [$];
    logic [31:0] cap_a [$];
    logic [31:0] cap_b [$];

    logic [31:0] cur_soc [4];
    logic [31:0] cur_I;
    logic [1:0]  exp_code [$];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] exp_i [4];

    function automatic real fp2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            2'b00:   return r2fp(fp2r(a) + fp2r(b));
            2'b01:   return r2fp(fp2r(a) * fp2r(b));
            default: return r2fp(1.0 / fp2r(a));
        endcase
    endfunction

    task automatic push_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r);
        exp_code.push_back(c);
        exp_a.push_back(a);
        exp_b.push_back(b);
        r = fp_op(c, a, b);
    endtask

    // Reference: weights, their sum, the scale I/sum, then weight*scale per cell
    task automatic model_run();
        logic [31:0] w [4];
        logic [31:0] acc, rden, ks;
        exp_code.delete(); exp_a.delete(); exp_b.delete();
        if (cur_I[30:0] == 31'd0) begin
            for (int k = 0; k < 4; k++) exp_i[k] = 32'd0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (cur_I[31]) push_op(2'b10, cur_soc[k], 32'd0, w[k]);
            else           w[k] = cur_soc[k];
        end
        acc = w[0];
        for (int k = 1; k < 4; k++) push_op(2'b00, acc, w[k], acc);
        push_op(2'b10, acc, 32'd0, rden);
        push_op(2'b01, cur_I, rden, ks);
        for (int k = 0; k < 4; k++) push_op(2'b01, w[k], ks, exp_i[k]);
    endtask

    function automatic int seq_diff(input int base);
        int bad = 0;
        for (int k = 0; k < exp_code.size(); k++) begin
            if (base + k >= cap_code.size()) bad++;
            else if (cap_code[base+k] !== exp_code[k] || cap_a[base+k] !== exp_a[k] ||
                     cap_b[base+k] !== exp_b[k]) bad++;
        end
        return bad;
    endfunction

    // FP unit stand-in: latency per request, optional stall, optional spurious acks
    initial begin : responder
        bit waiting, acked;
        int cnt, lat;
        logic [1:0]  hc;
        logic [31:0] ha, hb;
        waiting = 0; acked = 0; cnt = 0; lat = 0; hc = '0; ha = '0; hb = '0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (!rst_n) begin
                waiting = 0; acked = 0;
            end else if (ifc.op_req) begin
                if (acked) gap_err++;
                acked = 0;
                if (!waiting) begin
                    waiting = 1; cnt = 0;
                    lat = int'($urandom_range(lat_max, lat_min));
                    hc = ifc.op_code; ha = ifc.op_a; hb = ifc.op_b;
                    cap_code.push_back(hc); cap_a.push_back(ha); cap_b.push_back(hb);
                end else if (ifc.op_code !== hc || ifc.op_a !== ha || ifc.op_b !== hb) begin
                    stable_err++;
                end
                cnt++;
                if (!hold_off && cnt >= lat) begin
                    resp_ack = 1'b1; resp_result = fp_op(hc, ha, hb);
                    waiting = 0; acked = 1;
                end
            end else begin
                waiting = 0; acked = 0;
                if (spurious && $urandom_range(2, 0) == 0) begin
                    resp_ack = 1'b1; resp_result = $urandom;
                end
            end
        end
    end

    task automatic apply_start();
        @(negedge clk);
        soc1 = cur_soc[0]; soc2 = cur_soc[1]; soc3 = cur_soc[2]; soc4 = cur_soc[3]; I_in = cur_I;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit ok);
        ok = 0; cyc = 0;
        while (cyc < budget) begin
            if (done) begin ok = 1; break; end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_run(output bit ok, output int n_ops, output int base,
                          output logic [127:0] outs, output logic err_d, output logic done_next);
        int cyc;
        base = cap_code.size();
        apply_start();
        wait_done(5000, cyc, ok);
        n_ops = cap_code.size() - base;
        outs = {i1, i2, i3, i4};
        err_d = err;
        @(negedge clk);
        done_next = done;
    endtask

    function automatic logic [31:0] rnd_soc();
        return {1'b0, 8'($urandom_range(130, 120)), 23'($urandom)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ifc.op_req, ifc.op_code, ifc.op_a, ifc.op_b, i1, i2, i3, i4, busy, done, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: req=%b code=%b a=%h b=%h i=%h %h %h %h busy=%b done=%b err=%b, required all 0",
                     ifc.op_req, ifc.op_code, ifc.op_a, ifc.op_b, i1, i2, i3, i4, busy, done, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_discharge();
        bit ok; int n, base; logic [127:0] o; logic e, dn;
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 4; k++) cur_soc[k] = 32'h3F000000;
        cur_I = 32'h40000000;
        model_run();
        do_run(ok, n, base, o, e, dn);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL discharge_done: got %b required 1", ok); end
        n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL discharge_ops: got %0d required 9", n); end
        n_cmp++; if (seq_diff(base) !== 0) begin n_bad++; $display("FAIL discharge_seq: %0d wrong ops", seq_diff(base)); end
        n_cmp++; if (cap_a[base+3] !== 32'h40000000) begin n_bad++; $display("FAIL discharge_den: got %h required 40000000", cap_a[base+3]); end
        n_cmp++; if (o !== {4{32'h3F000000}}) begin n_bad++; $display("FAIL discharge_out: got %h required 4x3f000000", o); end
        n_cmp++; if ({e, dn} !== 2'b00) begin n_bad++; $display("FAIL discharge_err_pulse: err=%b done_next=%b required 0 0", e, dn); end
    endtask

    task automatic test_charge();
        bit ok; int n, base; logic [127:0] o; logic e, dn;
        for (int k = 0; k < 4; k++) cur_soc[k] = 32'h3F000000;
        cur_I = 32'hC0000000;
        model_run();
        do_run(ok, n, base, o, e, dn);
        n_cmp++; if (n !== 13) begin n_bad++; $display("FAIL charge_ops: got %0d required 13", n); end
        n_cmp++; if (seq_diff(base) !== 0) begin n_bad++; $display("FAIL charge_seq: %0d wrong ops", seq_diff(base)); end
        n_cmp++; if (cap_a[base+7] !== 32'h41000000 || cap_code[base+7] !== 2'b10) begin
            n_bad++; $display("FAIL charge_den: got %h code %b required 41000000 code 10", cap_a[base+7], cap_code[base+7]);
        end
        n_cmp++; if (o !== {4{32'hBF000000}}) begin n_bad++; $display("FAIL charge_out: got %h required 4xbf000000", o); end
        n_cmp++; if ({ok, e, dn} !== 3'b100) begin n_bad++; $display("FAIL charge_status: ok=%b err=%b done_next=%b required 1 0 0", ok, e, dn); end
    endtask

    task automatic test_timeout();
        logic [127:0] prev;
        int req_cyc, cyc;
        bit ok;
        logic e;
        prev = {i1, i2, i3, i4};
        hold_off = 1'b1;
        for (int k = 0; k < 4; k++) cur_soc[k] = 32'h3F000000;
        cur_I = 32'hC0000000;
        apply_start();
        req_cyc = 0; cyc = 0; ok = 0;
        while (cyc < 500) begin
            if (done) begin ok = 1; break; end
            if (ifc.op_req) req_cyc++;
            @(negedge clk);
            cyc++;
        end
        e = err;
        hold_off = 1'b0;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL timeout_done: got %b required 1", ok); end
        n_cmp++; if (req_cyc !== 64) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d required 64", req_cyc); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b required 1", e); end
        n_cmp++; if ({i1, i2, i3, i4} !== prev) begin n_bad++; $display("FAIL timeout_hold: got %h required %h", {i1, i2, i3, i4}, prev); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int n0;
        logic d1, d2;
        n0 = cap_code.size();
        for (int k = 0; k < 4; k++) cur_soc[k] = rnd_soc();
        cur_I = 32'h80000000;
        apply_start();
        d1 = done;
        @(negedge clk);
        d2 = done;
        n_cmp++; if ({d1, d2} !== 2'b01) begin n_bad++; $display("FAIL zero_timing: done=%b,%b required 0,1", d1, d2); end
        n_cmp++; if ({i1, i2, i3, i4} !== 128'd0) begin n_bad++; $display("FAIL zero_out: got %h required 0", {i1, i2, i3, i4}); end
        n_cmp++; if (cap_code.size() - n0 !== 0 || err !== 1'b0) begin
            n_bad++; $display("FAIL zero_noop: ops=%0d err=%b required 0 0", cap_code.size() - n0, err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit found, quiet, ok;
        int n, base;
        logic [127:0] o;
        logic e, dn;
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 4; k++) cur_soc[k] = 32'h3F000000;
        cur_I = 32'h40000000;
        apply_start();
        found = 0;
        for (int c = 0; c < 300; c++) begin
            if (ifc.op_req && ifc.op_code == 2'b00 && busy) begin found = 1; break; end
            @(negedge clk);
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_sum: got %b required 1", found); end
        rst_n = 1'b0;
        ack_inject = 1'b1;
        #1;
        n_cmp++;
        if ({ifc.op_req, ifc.op_code, ifc.op_a, ifc.op_b, i1, i2, i3, i4, busy, done, err} !== '0) begin
            n_bad++; $display("FAIL rstmid_clear: req=%b a=%h i1=%h busy=%b required all 0", ifc.op_req, ifc.op_a, i1, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ack_inject = 1'b0;
            if (ifc.op_req || busy || done || err) quiet = 0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL rstmid_late_ack: activity seen, required idle"); end
        for (int k = 0; k < 4; k++) cur_soc[k] = rnd_soc();
        cur_I = {1'b0, 8'd128, 23'($urandom)};
        model_run();
        do_run(ok, n, base, o, e, dn);
        n_cmp++; if (o !== {exp_i[0], exp_i[1], exp_i[2], exp_i[3]} || !ok || e) begin
            n_bad++; $display("FAIL rstmid_rerun: got %h ok=%b err=%b required %h ok=1 err=0", o, ok, e,
                              {exp_i[0], exp_i[1], exp_i[2], exp_i[3]});
        end
    endtask

    task automatic test_random();
        int base, cyc, s0, g0;
        bit ok;
        s0 = stable_err; g0 = gap_err;
        lat_min = 1; lat_max = 20; spurious = 1'b1;
        for (int run = 0; run < 8; run++) begin
            for (int k = 0; k < 4; k++) cur_soc[k] = rnd_soc();
            if ($urandom_range(4, 0) == 0) cur_I = {1'($urandom), 31'd0};
            else cur_I = {1'($urandom), 8'($urandom_range(135, 120)), 23'($urandom)};
            model_run();
            base = cap_code.size();
            apply_start();
            ok = 0; cyc = 0;
            while (cyc < 5000) begin
                if (done) begin start = 1'b0; ok = 1; break; end
                start = (busy && $urandom_range(7, 0) == 0);
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            n_cmp++; if (ok !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL random_done run %0d: ok=%b err=%b required 1 0", run, ok, err); end
            n_cmp++; if (cap_code.size() - base !== exp_code.size() || seq_diff(base) !== 0) begin
                n_bad++; $display("FAIL random_seq run %0d: ops=%0d required %0d, %0d wrong", run,
                                  cap_code.size() - base, exp_code.size(), seq_diff(base));
            end
            n_cmp++; if ({i1, i2, i3, i4} !== {exp_i[0], exp_i[1], exp_i[2], exp_i[3]}) begin
                n_bad++; $display("FAIL random_out run %0d: got %h required %h", run, {i1, i2, i3, i4},
                                  {exp_i[0], exp_i[1], exp_i[2], exp_i[3]});
            end
        end
        spurious = 1'b0;
        @(negedge clk);
        n_cmp++; if (stable_err - s0 !== 0) begin n_bad++; $display("FAIL random_operand_stable: %0d changes required 0", stable_err - s0); end
        n_cmp++; if (gap_err - g0 !== 0) begin n_bad++; $display("FAIL random_req_gap: %0d missing gaps required 0", gap_err - g0); end
    endtask

    task automatic test_back_to_back();
        int cyc, base;
        bit ok;
        logic b1, b2;
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 4; k++) cur_soc[k] = rnd_soc();
        cur_I = {1'b1, 8'd127, 23'($urandom)};
        model_run();
        apply_start();
        wait_done(5000, cyc, ok);
        n_cmp++; if ({i1, i2, i3, i4} !== {exp_i[0], exp_i[1], exp_i[2], exp_i[3]} || !ok) begin
            n_bad++; $display("FAIL b2b_first: got %h ok=%b required %h", {i1, i2, i3, i4}, ok, {exp_i[0], exp_i[1], exp_i[2], exp_i[3]});
        end
        for (int k = 0; k < 4; k++) cur_soc[k] = rnd_soc();
        cur_I = {1'b0, 8'd126, 23'($urandom)};
        model_run();
        base = cap_code.size();
        soc1 = cur_soc[0]; soc2 = cur_soc[1]; soc3 = cur_soc[2]; soc4 = cur_soc[3]; I_in = cur_I;
        start = 1'b1;
        @(negedge clk);
        b1 = busy;
        @(negedge clk);
        start = 1'b0;
        b2 = busy;
        n_cmp++; if ({b1, b2} !== 2'b01) begin n_bad++; $display("FAIL b2b_accept: busy=%b,%b required 0,1", b1, b2); end
        wait_done(5000, cyc, ok);
        n_cmp++; if ({i1, i2, i3, i4} !== {exp_i[0], exp_i[1], exp_i[2], exp_i[3]} || !ok || seq_diff(base) !== 0) begin
            n_bad++; $display("FAIL b2b_second: got %h ok=%b required %h", {i1, i2, i3, i4}, ok, {exp_i[0], exp_i[1], exp_i[2], exp_i[3]});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_discharge();
        test_charge();
        test_timeout();
        test_zero();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
